// File: rtl/regfile_storage.sv
// 32 x 64-bit architectural register file storage with a one-hot write decoder.
// Optional build macro: REGFILE_ZERO_REG_EN hardwires register 31 (XZR) to zero.
module regfile_storage (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [4:0]        writeRegister,
  input  logic [63:0]       writeData,
  output logic [31:0][63:0] regOut,
  output logic              writeDone
);

  localparam int unsigned NumRegs = 32;
  localparam int unsigned DataW   = 64;
  localparam int unsigned IdxW    = 5;
`ifdef REGFILE_ZERO_REG_EN
  localparam int unsigned NumStored = NumRegs - 1;
`else
  localparam int unsigned NumStored = NumRegs;
`endif

  logic [NumStored-1:0]            wr_en_c;
  logic [NumStored-1:0][DataW-1:0] regs_d, regs_q;
  logic                            done_d, done_q;

  // 5-to-32 decoder gated by regWrite; an XZR write decodes to no enable at all
  always_comb begin
    wr_en_c = '0;
    for (int unsigned i = 0; i < NumStored; i++) begin
      wr_en_c[i] = regWrite && (writeRegister == IdxW'(i));
    end
  end

  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < NumStored; i++) begin
      if (wr_en_c[i]) regs_d[i] = writeData;
    end
    done_d = regWrite;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
      done_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      done_q <= done_d;
    end
  end

  // Unstored slots (XZR when enabled) read as constant zero
  always_comb begin
    regOut = '0;
    for (int unsigned i = 0; i < NumStored; i++) begin
      regOut[i] = regs_q[i];
    end
  end

  assign writeDone = done_q;

endmodule

// File: tb/tb_regfile_storage.sv
// Scoreboard bench for regfile_storage: stimulus pushes expected state per cycle,
// a monitor pops and compares one cycle later. Honors REGFILE_ZERO_REG_EN.
module tb_regfile_storage;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  typedef struct packed {
    logic              done;
    logic [31:0][63:0] regs;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              regWrite;
  logic [4:0]        writeRegister;
  logic [63:0]       writeData;
  logic [31:0][63:0] regOut;
  logic              writeDone;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [63:0] model [32];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  regfile_storage dut (
    .clk           (clk),
    .reset         (reset),
    .regWrite      (regWrite),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .regOut        (regOut),
    .writeDone     (writeDone)
  );

  // Reference: architectural meaning of one cycle of inputs
  task automatic drive(input logic rst, input logic we, input logic [4:0] idx,
                       input logic [63:0] data);
    exp_t e;
    @(posedge clk);
    #2;
    reset = rst; regWrite = we; writeRegister = idx; writeData = data;
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 64'h0;
      e.done = 1'b0;
    end else begin
      if (we && !(ZeroReg && idx == 5'd31)) model[idx] = data;
      e.done = we;
    end
    for (int i = 0; i < 32; i++) e.regs[i] = model[i];
    exp_q.push_back(e);
  endtask

  // Downstream read-mux port model
  function automatic logic [63:0] read_port(input logic [31:0][63:0] bank, input logic [4:0] sel);
    return bank[sel];
  endfunction

  // Monitor: state produced by the edge just after each stimulus cycle
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (writeDone !== mon_e.done) begin
        failures++;
        $display("FAIL writeDone t=%0t got=%b exp=%b", $time, writeDone, mon_e.done);
      end
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (regOut[i] !== mon_e.regs[i]) begin
          failures++;
          $display("FAIL regOut[%0d] t=%0t got=%h exp=%h", i, $time, regOut[i], mon_e.regs[i]);
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #3;
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    logic [63:0] rd_a, rd_b, exp_a, exp_b;
    reset = 1'b1; regWrite = 1'b0; writeRegister = '0; writeData = '0;
    for (int i = 0; i < 32; i++) model[i] = 64'h0;

    drive(1'b1, 1'b0, 5'd0, 64'h0);
    // Arbitrary writes, then two reset cycles clear everything
    for (int i = 0; i < 8; i++)
      drive(1'b0, 1'b1, 5'($urandom_range(0, 31)), {$urandom, $urandom});
    drive(1'b1, 1'b0, 5'd0, 64'h0);
    drive(1'b1, 1'b1, 5'd2, 64'h55);
    drive(1'b0, 1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D);
    drive(1'b0, 1'b0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b0, 1'b1, 5'd3, 64'h1);
    drive(1'b0, 1'b1, 5'd3, 64'h2);
    drive(1'b0, 1'b0, 5'd0, 64'h0);
    drive(1'b0, 1'b1, 5'd31, 64'h1234);
    drive(1'b0, 1'b0, 5'd31, 64'h0);
    drive(1'b1, 1'b1, 5'd10, 64'hAA);
    drive(1'b0, 1'b0, 5'd10, 64'h0);

    // Every register i gets value i, then read back on two mux ports
    for (int i = 0; i < 32; i++) drive(1'b0, 1'b1, 5'(i), 64'(i));
    drive(1'b0, 1'b0, 5'd0, 64'h0);
    drain();
    for (int i = 0; i < 32; i++) begin
      rd_a  = read_port(regOut, 5'(i));
      rd_b  = read_port(regOut, 5'(31 - i));
      exp_a = (ZeroReg && i == 31) ? 64'h0 : 64'(i);
      exp_b = (ZeroReg && i == 0)  ? 64'h0 : 64'(31 - i);
      checks += 2;
      if (rd_a !== exp_a) begin
        failures++;
        $display("FAIL read_port_a[%0d] got=%h exp=%h", i, rd_a, exp_a);
      end
      if (rd_b !== exp_b) begin
        failures++;
        $display("FAIL read_port_b[%0d] got=%h exp=%h", 31 - i, rd_b, exp_b);
      end
    end

    // Random traffic with occasional reset, biased toward XZR and back-to-back hits
    for (int i = 0; i < 400; i++) begin
      logic [4:0] idx;
      idx = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), idx,
            {$urandom, $urandom});
    end
    drive(1'b0, 1'b0, 5'd0, 64'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
